// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined adder/subtractor with skewed slices, valid/ready flow control and flags
// Each stage ripples one SW-bit slice; a single global enable stalls the whole pipe.

module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;

  logic             en;
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] r_in  [STAGES];
  logic             c_in  [STAGES];
  logic             v_in  [STAGES];

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] r_q   [STAGES];
  logic             c_q   [STAGES];
  logic             v_q   [STAGES];

  logic [WIDTH-1:0] r_d   [STAGES];
  logic             c_d   [STAGES];
  logic [SW:0]      slice_sum [STAGES];
  logic             ovf_d, zero_d;
  logic             ovf_q, zero_q;

  // Stage 0 is fed from the ports; later stages from the previous stage's registers.
  always_comb begin
    a_in[0] = d0;
    b_in[0] = sub ? ~d1 : d1;
    r_in[0] = '0;
    c_in[0] = sub;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      r_in[k] = r_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, a_in[k][k*SW +: SW]} + {1'b0, b_in[k][k*SW +: SW]}
                   + {{SW{1'b0}}, c_in[k]};
      r_d[k] = r_in[k];
      r_d[k][k*SW +: SW] = slice_sum[k][SW-1:0];
      c_d[k] = slice_sum[k][SW];
    end
    // a ^ b ^ sum at the MSB recovers the carry into the MSB.
    ovf_d  = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
           ^ r_d[STAGES-1][WIDTH-1] ^ c_d[STAGES-1];
    zero_d = (r_d[STAGES-1] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        r_q[k] <= r_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_in[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign en        = out_ready || !v_q[STAGES-1];
  assign in_ready  = en;
  assign out_valid = v_q[STAGES-1];
  assign sum       = r_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
